// File: rtl/randomizer_frame_ctrl_pkg.sv
// Shared types and constants for the randomizer frame controller and its
// scrambling-sequence generator.
package randomizer_frame_ctrl_pkg;

    localparam int SYM_W = 2;
    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    localparam logic [17:0] X_SEED = 18'h00001;
    localparam logic [17:0] Y_SEED = 18'h3FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASM,
        ST_DATA
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/randomizer_frame_ctrl_if.sv
// Symbol stream bundle: upstream (i_data/i_valid/i_sof/o_ready) and
// downstream (o_data/o_valid/i_ready) handshakes of the frame controller.
interface randomizer_frame_ctrl_if;
    import randomizer_frame_ctrl_pkg::*;

    logic [SYM_W-1:0] i_data;
    logic             i_valid;
    logic             i_sof;
    logic             o_ready;
    logic [SYM_W-1:0] o_data;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output i_data, i_valid, i_sof, i_ready,
        input  o_ready, o_data, o_valid
    );

    modport slave (
        input  i_data, i_valid, i_sof, i_ready,
        output o_ready, o_data, o_valid
    );

endinterface

// File: rtl/randomizer_frame_ctrl_randomizer.sv
// Gold-sequence randomizer: two 18-bit LFSRs producing one 2-bit sequence
// value per enabled step; synchronous reset reloads the seeds.
module randomizer_frame_ctrl_randomizer
    import randomizer_frame_ctrl_pkg::*;
(
    output logic [1:0] o_r,
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en
);

    logic [17:0] x_q;
    logic [17:0] y_q;

    // Bit k of each register holds sequence element (i + k).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            x_q <= X_SEED;
            y_q <= Y_SEED;
        end else if (i_en) begin
            x_q <= {x_q[0] ^ x_q[7], x_q[17:1]};
            y_q <= {y_q[0] ^ y_q[5] ^ y_q[7] ^ y_q[10], y_q[17:1]};
        end
    end

    assign o_r[0] = x_q[0] ^ y_q[0];
    assign o_r[1] = x_q[4] ^ x_q[6] ^ x_q[15] ^ y_q[5] ^ y_q[6] ^ (^y_q[15:8]);

endmodule

// File: rtl/randomizer_frame_ctrl.sv
// Frame controller: forwards the sync marker unchanged, randomizes the data
// symbols, counts framing errors; one output register stage.
module randomizer_frame_ctrl
    import randomizer_frame_ctrl_pkg::*;
#(
    parameter int ASM_SYMS  = 16,
    parameter int DATA_SYMS = 64
)
(
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    randomizer_frame_ctrl_if.slave  bus,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic [ERR_W-1:0]        o_err_cnt
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [SYM_W-1:0] out_data_q, fwd_data;
    logic             out_valid_q, frame_done_q;
    logic [ERR_W-1:0] err_q;
    logic             accept, fwd, last_data, frame_err;
    logic             rand_reset, rand_en;
    logic [1:0]       rand_r;

    assign bus.o_ready = !out_valid_q || bus.i_ready;
    assign accept      = bus.i_valid && bus.o_ready;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    randomizer_frame_ctrl_randomizer u_randomizer (
        .o_r     (rand_r),
        .i_clk   (i_clk),
        .i_reset (rand_reset),
        .i_en    (rand_en)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sof restarts the frame from any state, so the sequence must also be
    // reseeded on that cycle in case the new frame skips straight to DATA.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fwd        = 1'b0;
        fwd_data   = bus.i_data;
        last_data  = 1'b0;
        frame_err  = 1'b0;
        rand_en    = accept && (state_q == ST_DATA);
        rand_reset = (state_q != ST_DATA) || (accept && bus.i_sof);
        if (accept) begin
            if (bus.i_sof) begin
                fwd       = 1'b1;
                frame_err = (state_q != ST_IDLE);
                state_d   = (ASM_SYMS == 1) ? ST_DATA : ST_ASM;
                cnt_d     = (ASM_SYMS == 1) ? '0 : CNT_W'(1);
            end else begin
                case (state_q)
                    ST_IDLE: frame_err = 1'b1;
                    ST_ASM: begin
                        fwd = 1'b1;
                        if (cnt_inc == CNT_W'(ASM_SYMS)) begin
                            cnt_d   = '0;
                            state_d = ST_DATA;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    ST_DATA: begin
                        fwd      = 1'b1;
                        fwd_data = bus.i_data ^ rand_r;
                        if (cnt_inc == CNT_W'(DATA_SYMS)) begin
                            last_data = 1'b1;
                            cnt_d     = '0;
                            state_d   = ST_IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            frame_done_q <= last_data;
            if (fwd) begin
                out_data_q  <= fwd_data;
                out_valid_q <= 1'b1;
            end else if (bus.i_ready) begin
                out_valid_q <= 1'b0;
            end
            if (frame_err) begin
                err_q <= sat_inc(err_q);
            end
        end
    end

    assign bus.o_data   = out_data_q;
    assign bus.o_valid  = out_valid_q;
    assign o_busy       = (state_q == ST_ASM) || (state_q == ST_DATA);
    assign o_frame_done = frame_done_q;
    assign o_err_cnt    = err_q;

endmodule

// File: tb/tb_randomizer_frame_ctrl.sv
// Scoreboard bench for randomizer_frame_ctrl: a frame-position model predicts
// every forwarded symbol; a monitor compares whatever the DUT hands downstream.
module tb_randomizer_frame_ctrl;

    localparam int ASM_SYMS  = 2;
    localparam int DATA_SYMS = 4;
    localparam int SEQ_LEN   = 64;

    logic       i_clk;
    logic       i_reset_n;
    logic       o_busy;
    logic       o_frame_done;
    logic [7:0] o_err_cnt;

    randomizer_frame_ctrl_if bus();

    randomizer_frame_ctrl #(
        .ASM_SYMS  (ASM_SYMS),
        .DATA_SYMS (DATA_SYMS)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_err_cnt    (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         n_checks;
    int         n_fails;
    int         pos;
    int         exp_err;
    int         exp_done;
    int         done_seen;
    bit         rand_ready;
    logic [1:0] exp_q[$];
    int         xs[SEQ_LEN + 18];
    int         ys[SEQ_LEN + 18];

    task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] req);
        n_fails++;
        $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) report_fail(name, act, req);
    endtask

    // Scrambling sequence element i, built from the two m-sequences as plain arrays.
    function automatic logic [1:0] rseq(input int i);
        int hi;
        hi = xs[i+4] ^ xs[i+6] ^ xs[i+15] ^ ys[i+5] ^ ys[i+6];
        for (int k = 8; k <= 15; k++) hi ^= ys[i+k];
        return {hi[0], 1'(xs[i] ^ ys[i])};
    endfunction

    // pos: -1 outside a frame, else index of the next symbol within the frame.
    task automatic model_accept(input logic [1:0] d, input bit sof);
        if (sof) begin
            if (pos >= 0 && exp_err < 255) exp_err++;
            exp_q.push_back(d);
            pos = 1;
        end else if (pos < 0) begin
            if (exp_err < 255) exp_err++;
        end else if (pos < ASM_SYMS) begin
            exp_q.push_back(d);
            pos++;
        end else begin
            exp_q.push_back(d ^ rseq(pos - ASM_SYMS));
            pos++;
            if (pos == ASM_SYMS + DATA_SYMS) begin
                exp_done++;
                pos = -1;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] d, input bit sof);
        int waited;
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sof   = sof;
        #1;
        waited = 0;
        while (!bus.o_ready && waited < 100) begin
            @(negedge i_clk);
            #1;
            waited++;
        end
        if (!bus.o_ready) begin
            n_checks++;
            report_fail("input_accept_timeout", 32'(bus.o_ready), 32'd1);
        end else begin
            model_accept(d, sof);
            @(posedge i_clk);
        end
        #1;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] asm_sym, input logic [1:0] data_sym);
        apply_stimulus(asm_sym, 1'b1);
        for (int i = 1; i < ASM_SYMS; i++) apply_stimulus(asm_sym, 1'b0);
        for (int i = 0; i < DATA_SYMS; i++) apply_stimulus(data_sym, 1'b0);
    endtask

    task automatic checkpoint(input string name);
        int waited;
        if (!rand_ready) bus.i_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge i_clk);
            #3;
            waited++;
        end
        repeat (2) @(negedge i_clk);
        #3;
        check_output({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check_output({name, "_err_cnt"}, 32'(o_err_cnt), 32'(exp_err));
        check_output({name, "_busy"}, 32'(o_busy), 32'(pos >= 0));
        check_output({name, "_frames_done"}, 32'(done_seen), 32'(exp_done));
    endtask

    task automatic check_reset_values(input string name);
        check_output({name, "_o_valid"}, 32'(bus.o_valid), 32'd0);
        check_output({name, "_o_data"}, 32'(bus.o_data), 32'd0);
        check_output({name, "_o_frame_done"}, 32'(o_frame_done), 32'd0);
        check_output({name, "_o_err_cnt"}, 32'(o_err_cnt), 32'd0);
        check_output({name, "_o_busy"}, 32'(o_busy), 32'd0);
        check_output({name, "_o_ready"}, 32'(bus.o_ready), 32'd1);
    endtask

    always @(negedge i_clk) begin
        if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops an expectation for every downstream transfer.
    initial begin
        bit         hold_prev;
        logic [1:0] hold_data;
        hold_prev = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_reset_n) begin
                if (o_frame_done) done_seen++;
                if (hold_prev && bus.o_valid) check_output("hold_stable", 32'(bus.o_data), 32'(hold_data));
                if (bus.o_valid && !bus.i_ready) check_output("ready_low_on_stall", 32'(bus.o_ready), 32'd0);
                if (bus.o_valid && bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        report_fail("unexpected_output", 32'(bus.o_data), 32'hFFFF_FFFF);
                    end else begin
                        check_output("out_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
                    end
                end
                hold_prev = bus.o_valid && !bus.i_ready;
                hold_data = bus.o_data;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        pos         = -1;
        exp_err     = 0;
        exp_done    = 0;
        done_seen   = 0;
        rand_ready  = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_sof   = 1'b0;
        bus.i_ready = 1'b1;
        i_reset_n   = 1'b0;

        for (int k = 0; k < 18; k++) begin
            xs[k] = (k == 0) ? 1 : 0;
            ys[k] = 1;
        end
        for (int k = 0; k < SEQ_LEN; k++) begin
            xs[k+18] = xs[k+7] ^ xs[k];
            ys[k+18] = ys[k+10] ^ ys[k+7] ^ ys[k+5] ^ ys[k];
        end

        repeat (3) @(negedge i_clk);
        #1;
        check_reset_values("por");
        i_reset_n = 1'b1;

        // Basic frame: 11, 11, then the sequence values for data 00.
        send_frame(2'b11, 2'b00);
        checkpoint("basic");

        // Same frame twice back-to-back.
        send_frame(2'b11, 2'b00);
        send_frame(2'b11, 2'b00);
        checkpoint("back_to_back");

        // Three-cycle downstream stall in the middle of DATA.
        apply_stimulus(2'b11, 1'b1);
        apply_stimulus(2'b11, 1'b0);
        apply_stimulus(2'b01, 1'b0);
        apply_stimulus(2'b10, 1'b0);
        fork
            apply_stimulus(2'b11, 1'b0);
            begin
                @(negedge i_clk);
                bus.i_ready = 1'b0;
                repeat (3) @(negedge i_clk);
                bus.i_ready = 1'b1;
            end
        join
        apply_stimulus(2'b00, 1'b0);
        checkpoint("stall");

        // Junk in IDLE, then sof on the second data symbol.
        apply_stimulus(2'b10, 1'b0);
        checkpoint("idle_junk");
        apply_stimulus(2'b11, 1'b1);
        apply_stimulus(2'b11, 1'b0);
        apply_stimulus(2'b01, 1'b0);
        apply_stimulus(2'b10, 1'b1);
        apply_stimulus(2'b01, 1'b0);
        checkpoint("sof_mid_data");
        for (int i = 0; i < DATA_SYMS; i++) apply_stimulus(2'(i), 1'b0);
        checkpoint("after_abort");

        // Reset pulse in the middle of DATA.
        apply_stimulus(2'b11, 1'b1);
        apply_stimulus(2'b11, 1'b0);
        apply_stimulus(2'b10, 1'b0);
        apply_stimulus(2'b01, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        exp_q.delete();
        pos     = -1;
        exp_err = 0;
        check_reset_values("mid_data_reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        send_frame(2'b11, 2'b00);
        checkpoint("post_reset");

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) apply_stimulus(2'($urandom_range(0, 3)), 1'b0);
        checkpoint("err_saturate");

        // Randomized frames with random backpressure, gaps and stray sofs.
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 7) == 0) apply_stimulus(2'($urandom_range(0, 3)), 1'b0);
            apply_stimulus(2'($urandom_range(0, 3)), 1'b1);
            for (int s = 1; s < ASM_SYMS + DATA_SYMS; s++) begin
                if ($urandom_range(0, 3) == 0) @(negedge i_clk);
                apply_stimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
            end
        end
        checkpoint("random");
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
